// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  localparam int unsigned MemBytesDefault = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // A 64-bit access must fit entirely inside the memory.
  function automatic logic addr_out_of_range(input logic [63:0] addr,
                                             input int unsigned mem_bytes);
    return addr > (64'(mem_bytes) - 64'd8);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester ports plus the data memory port of the arbiter, bundled as one bus.
interface data_mem_arbiter_if;

  logic        p0_req,   p1_req;
  logic        p0_we,    p1_we;
  logic [63:0] p0_addr,  p1_addr;
  logic [63:0] p0_wdata, p1_wdata;
  logic        p0_ack,   p1_ack;
  logic        p0_err,   p1_err;
  logic [63:0] p0_rdata, p1_rdata;

  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, Read_Data,
    output p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata,
           Mem_Addr, Write_Data, MemWrite, MemRead
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, Read_Data,
    input  p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata,
           Mem_Addr, Write_Data, MemWrite, MemRead
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way grant selection: round-robin on ties, or port 0 always wins when fixed_prio is set.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two 64-bit load/store requesters onto a single data memory port.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MemBytesDefault,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  data_mem_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;

  logic [1:0]  req;
  logic [1:0]  grant;
  logic        sel_id;
  logic        sel_we;
  logic        sel_oob;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_q),
    .fixed_prio (FIXED_PRIO),
    .grant      (grant)
  );

  always_comb begin
    sel_id    = grant[1];
    sel_we    = sel_id ? bus.p1_we    : bus.p0_we;
    sel_addr  = sel_id ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = sel_id ? bus.p1_wdata : bus.p0_wdata;
    sel_oob   = addr_out_of_range(sel_addr, MEM_BYTES);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    id_d     = id_q;
    err_d    = err_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          id_d   = sel_id;
          we_d   = sel_we;
          err_d  = sel_oob;
          last_d = sel_id;
          if (sel_oob) begin
            // Memory-side outputs keep their last values on a rejected access.
            state_d = StResp;
            if (sel_id) rdata1_d = '0;
            else        rdata0_d = '0;
          end else begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (!we_q) begin
          if (id_q) rdata1_d = bus.Read_Data;
          else      rdata0_d = bus.Read_Data;
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      id_q     <= id_d;
      err_q    <= err_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    bus.MemRead    = (state_q == StAccess) && !we_q;
    bus.MemWrite   = (state_q == StAccess) && we_q;
    bus.Mem_Addr   = addr_q;
    bus.Write_Data = wdata_q;
    bus.p0_ack     = (state_q == StResp) && !id_q;
    bus.p1_ack     = (state_q == StResp) && id_q;
    bus.p0_err     = bus.p0_ack && err_q;
    bus.p1_err     = bus.p1_ack && err_q;
    bus.p0_rdata   = rdata0_q;
    bus.p1_rdata   = rdata1_q;
  end

endmodule
